// File: rtl/i2c_arbiter.sv
// i2c_arbiter: shares one i2c_master between two requesters.
//   Port 0 is the camera poller and port 1 is the second bus client.
//   The grant rotates round-robin, one complete transaction at a time.
//   While a port holds the grant, its addr/rw/packets/data fields are routed to
//   the master. The master's data_req and data_ready strobes go back only to the
//   granted port. The SDA/SCL pins stay on the master.
//
// Parameters
//   TIMEOUT        watchdog limit in clk cycles per transaction. It only has an
//                  effect when I2C_ARB_TIMEOUT_EN is defined.
// Optional feature
//   I2C_ARB_TIMEOUT_EN  enables the transaction watchdog. When it is undefined,
//                       err0/err1 are tied to 0.
// Ports
//   clk, reset                   clock; synchronous active-high reset
//   req0/1, addr0/1, rw0/1       requester bus. Each requester holds req until its done.
//   pkts0/1, wdata0/1            byte count and write byte per requester
//   grant0/1                     registered bus ownership
//   dreq0/1, drdy0/1             i2c_data_req / i2c_data_ready, gated by grant
//   rdata                        i2c_data_in, broadcast to both requesters
//   done0/1, err0/1              one-cycle completion / watchdog-abort pulses
//   i2c_start, i2c_addr, i2c_rw,
//   i2c_packets, i2c_data        command outputs to the master
//   i2c_ready, i2c_data_req,
//   i2c_data_ready, i2c_data_in  status inputs from the master
module i2c_arbiter #(
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic [6:0] addr0,
  input  logic [6:0] addr1,
  input  logic       rw0,
  input  logic       rw1,
  input  logic [4:0] pkts0,
  input  logic [4:0] pkts1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic       grant0,
  output logic       grant1,
  output logic       dreq0,
  output logic       dreq1,
  output logic       drdy0,
  output logic       drdy1,
  output logic [7:0] rdata,
  output logic       done0,
  output logic       done1,
  output logic       err0,
  output logic       err1,
  output logic       i2c_start,
  output logic [6:0] i2c_addr,
  output logic       i2c_rw,
  output logic [4:0] i2c_packets,
  output logic [7:0] i2c_data,
  input  logic       i2c_ready,
  input  logic       i2c_data_req,
  input  logic       i2c_data_ready,
  input  logic [7:0] i2c_data_in
);

  typedef enum logic [1:0] {IDLE, START, BUSY, RELEASE} state_t;

  state_t     state, state_n;
  logic       sel, sel_n;
  logic       last, last_n;
  logic       start_n;
  logic [1:0] grant, grant_n;
  logic [1:0] done, done_n;

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int unsigned CW = ($clog2(TIMEOUT + 1) > 12) ? $clog2(TIMEOUT + 1) : 12;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    err, err_n;
`endif

  always_comb begin
    state_n = state;
    sel_n   = sel;
    last_n  = last;
    grant_n = grant;
    start_n = i2c_start;
    done_n  = '0;
`ifdef I2C_ARB_TIMEOUT_EN
    err_n   = '0;
    cnt_n   = cnt;
`endif
    case (state)
      IDLE: begin
        if (i2c_ready && (req0 || req1)) begin
          // When both ports request, the port not served last wins.
          sel_n   = (req0 && req1) ? ~last : req1;
          grant_n = sel_n ? 2'b10 : 2'b01;
          start_n = 1'b1;
          state_n = START;
`ifdef I2C_ARB_TIMEOUT_EN
          cnt_n   = '0;
`endif
        end
      end
      START: begin
        if (!i2c_ready) begin
          start_n = 1'b0;
          state_n = BUSY;
        end
      end
      BUSY: begin
        if (i2c_ready) begin
          done_n  = sel ? 2'b10 : 2'b01;
          last_n  = sel;
          state_n = RELEASE;
        end
      end
      RELEASE: begin
        grant_n = '0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
`ifdef I2C_ARB_TIMEOUT_EN
    // Normal completion in BUSY takes priority over a watchdog expiry in the same cycle.
    if ((state == START) || (state == BUSY && !i2c_ready)) begin
      if (cnt == LIMIT) begin
        err_n   = sel ? 2'b10 : 2'b01;
        start_n = 1'b0;
        last_n  = sel;
        state_n = RELEASE;
      end else begin
        cnt_n = cnt + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sel       <= 1'b0;
      last      <= 1'b1;
      grant     <= '0;
      done      <= '0;
      i2c_start <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
      cnt       <= '0;
      err       <= '0;
`endif
    end else begin
      state     <= state_n;
      sel       <= sel_n;
      last      <= last_n;
      grant     <= grant_n;
      done      <= done_n;
      i2c_start <= start_n;
`ifdef I2C_ARB_TIMEOUT_EN
      cnt       <= cnt_n;
      err       <= err_n;
`endif
    end
  end

  always_comb begin
    i2c_addr    = '0;
    i2c_rw      = 1'b0;
    i2c_packets = '0;
    i2c_data    = '0;
    if (|grant) begin
      i2c_addr    = sel ? addr1  : addr0;
      i2c_rw      = sel ? rw1    : rw0;
      i2c_packets = sel ? pkts1  : pkts0;
      i2c_data    = sel ? wdata1 : wdata0;
    end
  end

  assign grant0 = grant[0];
  assign grant1 = grant[1];
  assign done0  = done[0];
  assign done1  = done[1];
  assign dreq0  = i2c_data_req   & grant[0];
  assign dreq1  = i2c_data_req   & grant[1];
  assign drdy0  = i2c_data_ready & grant[0];
  assign drdy1  = i2c_data_ready & grant[1];
  assign rdata  = i2c_data_in;

`ifdef I2C_ARB_TIMEOUT_EN
  assign err0 = err[0];
  assign err1 = err[1];
`else
  assign err0 = 1'b0;
  assign err1 = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_arbiter.sv
// Self-checking bench for i2c_arbiter.
// The bench plays the role of the master through i2c_ready and the data strobes.
// The round-robin winner is predicted by a small model: it keeps the pending
// ports and the last port served.
module tb_i2c_arbiter;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [6:0] addr0 = '0, addr1 = '0;
  logic       rw0 = 1'b0, rw1 = 1'b0;
  logic [4:0] pkts0 = '0, pkts1 = '0;
  logic [7:0] wdata0 = '0, wdata1 = '0;
  logic       i2c_ready = 1'b1, i2c_data_req = 1'b0, i2c_data_ready = 1'b0;
  logic [7:0] i2c_data_in = '0;
  logic       grant0, grant1, dreq0, dreq1, drdy0, drdy1, done0, done1, err0, err1;
  logic       i2c_start, i2c_rw;
  logic [7:0] rdata, i2c_data;
  logic [6:0] i2c_addr;
  logic [4:0] i2c_packets;

  always #5 clk = ~clk;

  i2c_arbiter #(.TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1), .rw0(rw0), .rw1(rw1),
    .pkts0(pkts0), .pkts1(pkts1), .wdata0(wdata0), .wdata1(wdata1),
    .grant0(grant0), .grant1(grant1), .dreq0(dreq0), .dreq1(dreq1),
    .drdy0(drdy0), .drdy1(drdy1), .rdata(rdata), .done0(done0), .done1(done1),
    .err0(err0), .err1(err1), .i2c_start(i2c_start), .i2c_addr(i2c_addr),
    .i2c_rw(i2c_rw), .i2c_packets(i2c_packets), .i2c_data(i2c_data),
    .i2c_ready(i2c_ready), .i2c_data_req(i2c_data_req),
    .i2c_data_ready(i2c_data_ready), .i2c_data_in(i2c_data_in)
  );

  int checks = 0, errors = 0;
  int done0_cnt = 0, done1_cnt = 0, dreq0_cnt = 0, dreq1_cnt = 0;
  int g1_cnt = 0, both_cnt = 0, err_cnt = 0;

  // Event counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (done0 === 1'b1) done0_cnt++;
    if (done1 === 1'b1) done1_cnt++;
    if (dreq0 === 1'b1) dreq0_cnt++;
    if (dreq1 === 1'b1) dreq1_cnt++;
    if (grant1 === 1'b1) g1_cnt++;
    if (grant0 === 1'b1 && grant1 === 1'b1) both_cnt++;
    if (err0 === 1'b1 || err1 === 1'b1) err_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    i2c_ready = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    tick();
    chk("rst_grant", {grant1, grant0}, 2'b00);
    chk("rst_start", i2c_start, 1'b0);
    chk("rst_done", {done1, done0}, 2'b00);
    chk("rst_err", {err1, err0}, 2'b00);
    chk("rst_addr", i2c_addr, 7'h00);
    reset = 1'b0;
  endtask

  // Waits for a grant, then plays one master transaction with lat busy cycles.
  // During those cycles the data strobes are random.
  task automatic serve(input int lat, input bit keep, output int port);
    int n;
    logic [7:0] bi;
    n = 0;
    port = -1;
    do begin
      tick();
      n++;
    end while (i2c_start !== 1'b1 && n < 20);
    chk("start_seen", i2c_start, 1'b1);
    if (i2c_start !== 1'b1) return;
    port = (grant1 === 1'b1) ? 1 : 0;
    chk("grant_onehot", 32'(grant0 ^ grant1), 1);
    chk("mux_addr", i2c_addr, (port == 1) ? addr1 : addr0);
    chk("mux_rw", i2c_rw, (port == 1) ? rw1 : rw0);
    chk("mux_pkts", i2c_packets, (port == 1) ? pkts1 : pkts0);
    chk("mux_data", i2c_data, (port == 1) ? wdata1 : wdata0);
    i2c_ready = 1'b0;
    tick();
    chk("start_drop", i2c_start, 1'b0);
    for (int i = 0; i < lat; i++) begin
      i2c_data_req = 1'($urandom_range(0, 1));
      i2c_data_ready = 1'($urandom_range(0, 1));
      bi = 8'($urandom);
      i2c_data_in = bi;
      #1;
      chk("dreq_gate", {dreq1, dreq0},
          i2c_data_req ? ((port == 1) ? 2'b10 : 2'b01) : 2'b00);
      chk("drdy_gate", {drdy1, drdy0},
          i2c_data_ready ? ((port == 1) ? 2'b10 : 2'b01) : 2'b00);
      chk("rdata", rdata, bi);
      chk("busy_nodone", {done1, done0}, 2'b00);
      tick();
    end
    i2c_data_req = 1'b0;
    i2c_data_ready = 1'b0;
    i2c_ready = 1'b1;
    tick();
    chk("done_pulse", {done1, done0}, (port == 1) ? 2'b10 : 2'b01);
    if (!keep) begin
      if (port == 1) req1 = 1'b0;
      else req0 = 1'b0;
    end
    tick();
    chk("release", {grant1, grant0, done1, done0}, 4'b0000);
  endtask

  initial begin
    int p, d0, d1, g1, q0, q1, exp_p, last_m;
    bit p0, p1, keep;

    do_reset();

    // 1: single request from port 0
    g1 = g1_cnt;
    addr0 = 7'h58; rw0 = 1'b0; pkts0 = 5'd2; wdata0 = 8'h11;
    req0 = 1'b1;
    tick();
    chk("t1_grant0", {grant1, grant0}, 2'b01);
    chk("t1_start", i2c_start, 1'b1);
    chk("t1_addr", i2c_addr, 7'h58);
    chk("t1_pkts", i2c_packets, 5'd2);
    i2c_ready = 1'b0;
    tick();
    chk("t1_start_low", i2c_start, 1'b0);
    tick();
    tick();
    chk("t1_nodone", done0, 1'b0);
    i2c_ready = 1'b1;
    tick();
    chk("t1_done0", {done1, done0}, 2'b01);
    req0 = 1'b0;
    tick();
    chk("t1_done_once", {done0, grant0}, 2'b00);
    tick();
    chk("t1_idle", {grant1, grant0, i2c_start}, 3'b000);
    chk("t1_no_grant1", 32'(g1_cnt - g1), 0);

    // 2: simultaneous requests after reset. Port 0 is served first.
    do_reset();
    d0 = done0_cnt; d1 = done1_cnt;
    addr1 = 7'h21; pkts1 = 5'd1;
    req0 = 1'b1; req1 = 1'b1;
    serve(2, 1'b0, p);
    chk("t2_first", 32'(p), 0);
    serve(1, 1'b0, p);
    chk("t2_second", 32'(p), 1);
    chk("t2_done0_cnt", 32'(done0_cnt - d0), 1);
    chk("t2_done1_cnt", 32'(done1_cnt - d1), 1);

    // 3: port 0 keeps requesting, port 1 arrives during BUSY
    req0 = 1'b1;
    tick();
    chk("t3_grant0", {grant1, grant0}, 2'b01);
    i2c_ready = 1'b0;
    tick();
    req1 = 1'b1;
    tick();
    i2c_ready = 1'b1;
    tick();
    chk("t3_done0", {done1, done0}, 2'b01);
    tick();
    chk("t3_release", {grant1, grant0}, 2'b00);
    serve(1, 1'b0, p);
    chk("t3_port1_next", 32'(p), 1);
    serve(0, 1'b0, p);
    chk("t3_port0_after", 32'(p), 0);

    // 4: data_req pulses reach only the granted port 1
    q0 = dreq0_cnt; q1 = dreq1_cnt;
    wdata1 = 8'hA5;
    req1 = 1'b1;
    tick();
    chk("t4_grant1", {grant1, grant0}, 2'b10);
    i2c_ready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      i2c_data_req = 1'b1;
      #1;
      chk("t4_dreq", {dreq1, dreq0}, 2'b10);
      chk("t4_wdata", i2c_data, 8'hA5);
      tick();
      i2c_data_req = 1'b0;
      tick();
    end
    i2c_ready = 1'b1;
    tick();
    chk("t4_done1", {done1, done0}, 2'b10);
    req1 = 1'b0;
    tick();
    chk("t4_dreq1_cnt", 32'(dreq1_cnt - q1), 3);
    chk("t4_dreq0_cnt", 32'(dreq0_cnt - q0), 0);

    // 5: reset while BUSY drops everything, then port 1 is served normally
    d0 = done0_cnt;
    req0 = 1'b1;
    tick();
    i2c_ready = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    i2c_ready = 1'b1;
    tick();
    chk("t5_rst", {grant1, grant0, i2c_start, done1, done0}, 5'b00000);
    reset = 1'b0;
    req0 = 1'b0;
    req1 = 1'b1;
    serve(1, 1'b0, p);
    chk("t5_port1", 32'(p), 1);
    chk("t5_no_done0", 32'(done0_cnt - d0), 0);

    // Randomized round-robin against the model
    do_reset();
    last_m = 1;
    p0 = 1'b0;
    p1 = 1'b0;
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 1) == 1) p0 = 1'b1;
      if ($urandom_range(0, 1) == 1) p1 = 1'b1;
      if (!p0 && !p1) begin
        if ($urandom_range(0, 1) == 1) p1 = 1'b1;
        else p0 = 1'b1;
      end
      addr0 = 7'($urandom); addr1 = 7'($urandom);
      rw0 = 1'($urandom); rw1 = 1'($urandom);
      pkts0 = 5'($urandom); pkts1 = 5'($urandom);
      wdata0 = 8'($urandom); wdata1 = 8'($urandom);
      req0 = p0;
      req1 = p1;
      exp_p = (p0 && p1) ? (1 - last_m) : (p1 ? 1 : 0);
      keep = ($urandom_range(0, 3) == 0);
      serve(int'($urandom_range(0, 4)), keep, p);
      chk("rr_winner", 32'(p), 32'(exp_p));
      last_m = p;
      if (!keep) begin
        if (p == 1) p1 = 1'b0;
        else p0 = 1'b0;
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    tick();
    chk("no_err_pulses", 32'(err_cnt), 0);

`ifdef I2C_ARB_TIMEOUT_EN
    // 6: hung master. err0 fires 64 cycles after entering START.
    d0 = done0_cnt;
    req0 = 1'b1;
    tick();
    chk("t6_grant0", {grant1, grant0, i2c_start}, 3'b011);
    i2c_ready = 1'b0;
    for (int i = 0; i < 63; i++) tick();
    chk("t6_no_err_early", {err1, err0, grant0}, 3'b001);
    tick();
    chk("t6_err0", {err1, err0}, 2'b01);
    chk("t6_start_low", i2c_start, 1'b0);
    req0 = 1'b0;
    tick();
    chk("t6_grant_drop", {grant1, grant0, err0}, 3'b000);
    chk("t6_no_done0", 32'(done0_cnt - d0), 0);
    i2c_ready = 1'b1;
    tick();
`endif

    chk("grant_exclusive", 32'(both_cnt), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench time limit");
  end
endmodule
